// File: rtl/audio_decimator.sv
// audio_decimator
//   Box-car decimator for the APU mix. Each window of 2^LOG2_DECIM qualified
//   input samples is averaged, attenuated by a right shift, and optionally
//   passed through a first-order DC blocker. The result appears as a
//   registered output sample with a one-cycle update strobe.
//
//   Build option: define AUDIO_DECIMATOR_DC_BLOCK_EN to include the DC blocker.
//   Without it, no filter state exists, the output is the attenuated average,
//   and the silence / reset value is 0x0000. With it, the silence / reset
//   value is 0x8000, the mid-scale code.
//
// Parameters
//   LOG2_DECIM : log2 of the decimation ratio (1..8)
//   DC_SHIFT   : DC-blocker pole shift; the leak term is y_prev >>> DC_SHIFT
//
// Ports
//   clk        in   system clock (the only clock)
//   resetn     in   asynchronous active-low reset
//   in_valid   in   one-cycle strobe qualifying in_sample
//   in_sample  in   16-bit unsigned mix sample
//   vol        in   attenuation, right-shift count (0 = full scale)
//   mute       in   forces the silence value; internal state keeps advancing
//   out_sample out  16-bit unsigned output, held between updates
//   out_valid  out  one-cycle pulse when out_sample updates
//
// Timing: the in_valid that completes a window is accepted at edge N, the
// average is registered at that edge, and the output register loads at edge
// N+1, so out_valid is high during the second cycle after the strobe.

module audio_decimator #(
  parameter int LOG2_DECIM = 5,
  parameter int DC_SHIFT   = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [15:0] in_sample,
  input  logic [2:0]  vol,
  input  logic        mute,
  output logic [15:0] out_sample,
  output logic        out_valid
);

  localparam int AW = 16 + LOG2_DECIM;

`ifdef AUDIO_DECIMATOR_DC_BLOCK_EN
  localparam logic [15:0] SILENCE = 16'h8000;
`else
  localparam logic [15:0] SILENCE = 16'h0000;
`endif

  // ---------------------------------------------------------------------
  // Stage 1: window accumulation
  // ---------------------------------------------------------------------
  logic [AW-1:0]         acc_q, acc_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic [15:0]           avg_q, avg_d;
  logic                  avg_vld_q, avg_vld_d;
  logic [AW-1:0]         sum;

  // The window total of 2^LOG2_DECIM 16-bit samples always fits in AW bits.
  assign sum = acc_q + AW'(in_sample);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    avg_vld_d = 1'b0;
    if (in_valid) begin
      if (cnt_q == '1) begin
        // Close the window and restart from zero in the same edge, so a
        // strobe in the very next cycle belongs to the new window.
        acc_d     = '0;
        cnt_d     = '0;
        avg_d     = sum[AW-1:LOG2_DECIM];
        avg_vld_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      avg_vld_q <= avg_vld_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: attenuation, optional DC blocker, output register
  // ---------------------------------------------------------------------
  logic [15:0] x;
  logic [15:0] out_sample_q, out_sample_d;
  logic        out_valid_q, out_valid_d;

  assign x = avg_q >> vol;

`ifdef AUDIO_DECIMATOR_DC_BLOCK_EN
  logic        [15:0] x_prev_q, x_prev_d;
  logic signed [15:0] y_prev_q, y_prev_d;
  logic signed [18:0] x_s, xp_s, yp_s, leak, y_wide;
  logic signed [15:0] y_sat;

  // 19 signed bits hold x - x_prev + y_prev - leak without overflow.
  assign x_s    = $signed({3'b000, x});
  assign xp_s   = $signed({3'b000, x_prev_q});
  assign yp_s   = {{3{y_prev_q[15]}}, y_prev_q};
  assign leak   = yp_s >>> DC_SHIFT;
  assign y_wide = x_s - xp_s + yp_s - leak;

  always_comb begin
    if (y_wide > 19'sd32767) begin
      y_sat = 16'sh7FFF;
    end else if (y_wide < -19'sd32768) begin
      y_sat = 16'sh8000;
    end else begin
      y_sat = y_wide[15:0];
    end
  end

  always_comb begin
    x_prev_d     = x_prev_q;
    y_prev_d     = y_prev_q;
    out_sample_d = out_sample_q;
    out_valid_d  = avg_vld_q;
    if (avg_vld_q) begin
      // Filter state advances even while muted.
      x_prev_d     = x;
      y_prev_d     = y_sat;
      // Adding 0x8000 to a 16-bit two's-complement value flips its MSB.
      out_sample_d = mute ? SILENCE : {~y_sat[15], y_sat[14:0]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else begin
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
    end
  end
`else
  always_comb begin
    out_sample_d = out_sample_q;
    out_valid_d  = avg_vld_q;
    if (avg_vld_q) begin
      out_sample_d = mute ? SILENCE : x;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_sample_q <= SILENCE;
      out_valid_q  <= 1'b0;
    end else begin
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_audio_decimator.sv
// Directed bench for audio_decimator at default parameters (32-sample window,
// DC_SHIFT = 10). Inputs change and outputs are sampled on the falling edge.
// A monitor logs every out_valid pulse (cycle number and value); the directed
// sequence compares those logs against hand-computed values. With
// AUDIO_DECIMATOR_DC_BLOCK_EN defined, the filter-specific sequence runs in
// place of the plain one.

module tb_audio_decimator;

  localparam int WIN = 32;

`ifdef AUDIO_DECIMATOR_DC_BLOCK_EN
  localparam logic [15:0] SIL = 16'h8000;
  localparam logic [15:0] OFS = 16'h8000;
`else
  localparam logic [15:0] SIL = 16'h0000;
  localparam logic [15:0] OFS = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [15:0] in_sample;
  logic [2:0]  vol;
  logic        mute;
  logic [15:0] out_sample;
  logic        out_valid;

  audio_decimator dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .vol        (vol),
    .mute       (mute),
    .out_sample (out_sample),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // out_valid event log
  int          ov_count = 0;
  int          ov_cyc_log [256];
  logic [15:0] ov_val_log [256];
  logic        ov_prev = 1'b0;
  logic        dbl = 1'b0;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      ov_cyc_log[ov_count[7:0]] <= cyc;
      ov_val_log[ov_count[7:0]] <= out_sample;
      ov_count <= ov_count + 1;
    end
    dbl     <= dbl | (out_valid & ov_prev);
    ov_prev <= out_valid;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One window of WIN strobes alternating samples a (even) / b (odd), with
  // gap idle cycles after each strobe (0 = back-to-back).
  task automatic run_window(input logic [15:0] a, input logic [15:0] b, input int gap);
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = k[0] ? b : a;
      if (gap > 0) begin
        @(negedge clk);
        in_valid  = 1'b0;
        in_sample = 16'hDEAD;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_sample = 16'hDEAD;
    repeat (3) @(negedge clk);
  endtask

  // Expect exactly one new output since base, with the given value.
  task automatic expect_one(input string tag, input int base, input logic [15:0] exp);
    check_int({tag, "_count"}, ov_count, base + 1);
    check16({tag, "_value"}, ov_val_log[base[7:0]], exp);
  endtask

  int base;
  int c_last;
  int c_start;

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_sample = 16'h0000;
    vol       = 3'd0;
    mute      = 1'b0;
    repeat (3) @(negedge clk);
    check16("reset_out_sample", out_sample, SIL);
    check16("reset_out_valid", {15'd0, out_valid}, 16'h0000);
    resetn = 1'b1;

    // 32 strobes of 0x1000, one every 12 clocks; samples during gaps are junk
    base = ov_count;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 16'h1000;
      c_last    = cyc;
      @(negedge clk);
      in_valid  = 1'b0;
      in_sample = 16'hDEAD;
      if (k == WIN - 2) check_int("spaced_no_early_output", ov_count, base);
      if (k == WIN - 1) check16("spaced_latency_not_1", {15'd0, out_valid}, 16'h0000);
      repeat (10) @(negedge clk);
    end
    expect_one("spaced_window", base, 16'h1000 + OFS);
    check_int("spaced_latency", ov_cyc_log[base[7:0]], c_last + 2);
    check16("spaced_hold_value", out_sample, 16'h1000 + OFS);
    check16("spaced_hold_valid", {15'd0, out_valid}, 16'h0000);

    // Reset after 20 strobes discards the partial window
    base = ov_count;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 16'h1234;
    end
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b0;
    repeat (2) @(negedge clk);
    check16("midreset_out_sample", out_sample, SIL);
    check16("midreset_out_valid", {15'd0, out_valid}, 16'h0000);
    // First strobe is presented together with reset release
    resetn    = 1'b1;
    in_valid  = 1'b1;
    in_sample = 16'h2000;
    for (int k = 1; k < WIN - 1; k++) begin
      @(negedge clk);
      in_sample = 16'h2000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_int("postreset_31_no_output", ov_count, base);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 16'h2000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    expect_one("postreset_window", base, 16'h2000 + OFS);

    // Reset between the completing strobe and the output edge
    base = ov_count;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 16'h3000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    resetn   = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_int("inflight_dropped", ov_count, base);
    check16("inflight_out_sample", out_sample, SIL);

`ifdef AUDIO_DECIMATOR_DC_BLOCK_EN
    // Constant 0x4000: y = 16384, then y - (y >>> 10) each window
    base = ov_count;
    run_window(16'h4000, 16'h4000, 0);
    expect_one("dc_first", base, 16'hC000);
    base = ov_count;
    run_window(16'h4000, 16'h4000, 0);
    expect_one("dc_decay1", base, 16'hBFF0);
    base = ov_count;
    run_window(16'h4000, 16'h4000, 0);
    expect_one("dc_decay2", base, 16'hBFE1);
    // Drop to 0: y = 0 - 16384 + 16353 - 15 = -46
    base = ov_count;
    run_window(16'h0000, 16'h0000, 0);
    expect_one("dc_drop", base, 16'h7FD2);
    // Step to 0xFFFF: 65535 - 46 + 1 saturates to 32767
    base = ov_count;
    run_window(16'hFFFF, 16'hFFFF, 0);
    expect_one("dc_step_sat", base, 16'hFFFF);
    // Muted window: silence out, state moves to y = 32767 - 31 = 32736
    mute = 1'b1;
    base = ov_count;
    run_window(16'hFFFF, 16'hFFFF, 0);
    expect_one("dc_mute", base, 16'h8000);
    mute = 1'b0;
    // 32736 - 31 = 32705 -> 0xFFC1
    base = ov_count;
    run_window(16'hFFFF, 16'hFFFF, 0);
    expect_one("dc_after_mute", base, 16'hFFC1);
`else
    // in_valid held high for 64 cycles, sample = index
    base = ov_count;
    for (int i = 0; i < 2 * WIN; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 16'(i);
      if (i == 0) c_start = cyc;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_sample = 16'hDEAD;
    repeat (3) @(negedge clk);
    check_int("ramp_count", ov_count, base + 2);
    check_int("ramp_cyc0", ov_cyc_log[base[7:0]], c_start + 33);
    check16("ramp_val0", ov_val_log[base[7:0]], 16'h000F);
    check_int("ramp_cyc1", ov_cyc_log[8'(base + 1)], c_start + 65);
    check16("ramp_val1", ov_val_log[8'(base + 1)], 16'h002F);

    // 0xFFFF with vol = 3
    vol  = 3'd3;
    base = ov_count;
    run_window(16'hFFFF, 16'hFFFF, 0);
    expect_one("vol3", base, 16'h1FFF);
    // Muted: silence, still one pulse per window
    mute = 1'b1;
    base = ov_count;
    run_window(16'hFFFF, 16'hFFFF, 2);
    expect_one("mute", base, 16'h0000);
    mute = 1'b0;
    // vol = 7
    vol  = 3'd7;
    base = ov_count;
    run_window(16'hFFFF, 16'hFFFF, 1);
    expect_one("vol7", base, 16'h01FF);
    // Average truncates: 16 * 3 / 32 = 1
    vol  = 3'd0;
    base = ov_count;
    run_window(16'h0000, 16'h0003, 0);
    expect_one("truncate", base, 16'h0001);
    // Full scale at vol = 0
    base = ov_count;
    run_window(16'hFFFF, 16'hFFFF, 0);
    expect_one("full_scale", base, 16'hFFFF);
`endif

    repeat (4) @(negedge clk);
    check16("no_double_pulse", {15'd0, dbl}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
